// File: rtl/nibble_cmp_pkg.sv
// rtl/nibble_cmp_pkg.sv - shared types and constants for the sequential nibble comparator
package nibble_cmp_pkg;

  localparam int NIBBLE_W = 4;

  // Cascade bit positions within {G, Gb, E}
  localparam int CASC_G  = 2;
  localparam int CASC_GB = 1;
  localparam int CASC_E  = 0;

  // Cascade value meaning "all more significant nibbles equal so far"
  localparam logic [2:0] CASC_RESET = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_cmp.sv
// rtl/nibble_cmp.sv - combinational 4-bit comparator with {G,Gb,E} cascade input
module nibble_cmp
  import nibble_cmp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic [2:0]          casc_i,
  output logic                g_o,
  output logic                e_o,
  output logic                gb_o
);

  // A decided cascade from more significant nibbles wins; otherwise this nibble decides
  always_comb begin
    g_o  = 1'b0;
    e_o  = 1'b0;
    gb_o = 1'b0;
    if (casc_i[CASC_G]) begin
      g_o = 1'b1;
    end else if (casc_i[CASC_GB]) begin
      gb_o = 1'b1;
    end else if (a_i > b_i) begin
      g_o = 1'b1;
    end else if (a_i < b_i) begin
      gb_o = 1'b1;
    end else begin
      e_o = casc_i[CASC_E];
    end
  end

endmodule

// File: rtl/nibble_seq_comparator.sv
// rtl/nibble_seq_comparator.sv - MSB-first nibble-serial magnitude comparator (option: NIBBLE_SEQ_COMPARATOR_EARLY_EXIT_EN)
module nibble_seq_comparator
  import nibble_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_ip,
  input  logic             rst_ip,
  input  logic             start_ip,
  input  logic [WIDTH-1:0] a_ip,
  input  logic [WIDTH-1:0] b_ip,
  input  logic             signed_ip,
  output logic             ready_op,
  output logic             busy_op,
  output logic             done_op,
  output logic             a_op_G,
  output logic             a_op_E_b,
  output logic             b_op_G
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               signed_q, signed_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         casc_q, casc_d;
  logic               g_q, g_d;
  logic               e_q, e_d;
  logic               gb_q, gb_d;

  logic [N-1:0][NIBBLE_W-1:0] a_nib, b_nib;
  logic [NIBBLE_W-1:0]        nib_a, nib_b;
  logic                       sign_flip;
  logic                       cmp_g, cmp_e, cmp_gb;
  logic                       run_last;

  assign a_nib = a_q;
  assign b_nib = b_q;

  // Two's-complement order becomes unsigned order once the sign bits are flipped
  assign sign_flip = signed_q && (idx_q == IDX_MSB);
  assign nib_a     = a_nib[idx_q] ^ {sign_flip, 3'b000};
  assign nib_b     = b_nib[idx_q] ^ {sign_flip, 3'b000};

  nibble_cmp u_nibble_cmp (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .casc_i (casc_q),
    .g_o    (cmp_g),
    .e_o    (cmp_e),
    .gb_o   (cmp_gb)
  );

`ifdef NIBBLE_SEQ_COMPARATOR_EARLY_EXIT_EN
  // Once the cascade is decided the remaining nibbles cannot change it
  assign run_last = (idx_q == '0) || !cmp_e;
`else
  assign run_last = (idx_q == '0);
`endif

  // Next-state, datapath next values and state-decoded outputs
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    casc_d   = casc_q;
    g_d      = g_q;
    e_d      = e_q;
    gb_d     = gb_q;
    ready_op = 1'b0;
    busy_op  = 1'b0;
    done_op  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_op = 1'b1;
        if (start_ip) begin
          state_d  = RUN;
          a_d      = a_ip;
          b_d      = b_ip;
          signed_d = signed_ip;
          idx_d    = IDX_MSB;
          casc_d   = CASC_RESET;
        end
      end
      RUN: begin
        busy_op = 1'b1;
        casc_d  = {cmp_g, cmp_gb, cmp_e};
        if (run_last) begin
          state_d = DONE;
          g_d     = cmp_g;
          e_d     = cmp_e;
          gb_d    = cmp_gb;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        busy_op = 1'b1;
        done_op = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_ip or posedge rst_ip) begin
    if (rst_ip) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, cascade, index and result registers
  always_ff @(posedge clk_ip or posedge rst_ip) begin
    if (rst_ip) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      casc_q   <= CASC_RESET;
      g_q      <= 1'b0;
      e_q      <= 1'b0;
      gb_q     <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      casc_q   <= casc_d;
      g_q      <= g_d;
      e_q      <= e_d;
      gb_q     <= gb_d;
    end
  end

  assign a_op_G   = g_q;
  assign a_op_E_b = e_q;
  assign b_op_G   = gb_q;

endmodule

// File: tb/tb_nibble_seq_comparator.sv
// tb/tb_nibble_seq_comparator.sv - self-checking bench for nibble_seq_comparator (WIDTH=16)
module tb_nibble_seq_comparator;

  localparam int W = 16;
  localparam int N = W / 4;
  localparam int LAT_FULL = N + 1;
`ifdef NIBBLE_SEQ_COMPARATOR_EARLY_EXIT_EN
  localparam int LAT_MSB = 2;
`else
  localparam int LAT_MSB = N + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sgn = 1'b0;
  logic         ready_op, busy_op, done_op, a_op_G, a_op_E_b, b_op_G;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_seq_comparator #(.WIDTH(W)) dut (
    .clk_ip    (clk),
    .rst_ip    (rst),
    .start_ip  (start),
    .a_ip      (a),
    .b_ip      (b),
    .signed_ip (sgn),
    .ready_op  (ready_op),
    .busy_op   (busy_op),
    .done_op   (done_op),
    .a_op_G    (a_op_G),
    .a_op_E_b  (a_op_E_b),
    .b_op_G    (b_op_G)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result flags {A>B, A==B, A<B} straight from the numeric values
  function automatic logic [2:0] model_flags(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if ($signed(x) < $signed(y)) return 3'b001;
      return 3'b010;
    end
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
    return 3'b010;
  endfunction

  // RUN cycles: all N, or up to the first differing nibble from the MSB when exiting early
  function automatic int model_run_cycles(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef NIBBLE_SEQ_COMPARATOR_EARLY_EXIT_EN
    logic [W-1:0] d;
    d = x ^ y;
    for (int k = 0; k < N; k++) begin
      if (d[W-1-4*k -: 4] != 4'h0) return k + 1;
    end
    return N;
`else
    return N;
`endif
  endfunction

  // Cycle-level expectation: busy from the cycle after acceptance through the done cycle
  int          cyc = 0;
  int          busy_end = -1;
  logic [2:0]  m_flags = 3'b000;
  logic [2:0]  pend = 3'b000;
  always @(negedge clk) begin
    logic e_busy, e_done;
    cyc++;
    if (rst) begin
      busy_end = -1;
      m_flags  = 3'b000;
    end else if (busy_end == cyc) begin
      m_flags = pend;
    end
    e_busy = !rst && (busy_end >= cyc);
    e_done = !rst && (busy_end == cyc);
    check("mon_ready", ready_op, !e_busy);
    check("mon_busy", busy_op, e_busy);
    check("mon_done", done_op, e_done);
    check("mon_flags", {a_op_G, a_op_E_b, b_op_G}, m_flags);
    if (!rst && !e_busy && start) begin
      busy_end = cyc + model_run_cycles(a, b) + 1;
      pend     = model_flags(a, b, sgn);
    end
  end

  // Waits for done_op; cycle 1 is the cycle that begins with the accepting edge
  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    lat = 1;
    while (!done_op && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic [2:0] exp_f, input int exp_lat);
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y; sgn = s;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(name, exp_lat);
    check({name, "_flags"}, {a_op_G, a_op_E_b, b_op_G}, exp_f);
    check({name, "_model"}, model_flags(x, y, s), exp_f);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!ready_op && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_ready_bound", ready_op, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", ready_op, 1'b1);
    check("reset_busy", busy_op, 1'b0);
    check("reset_done", done_op, 1'b0);
    check("reset_flags", {a_op_G, a_op_E_b, b_op_G}, 3'b000);
    rst = 1'b0;

    directed("eq_1234", 16'h1234, 16'h1234, 1'b0, 3'b010, LAT_FULL);
    directed("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b100, LAT_MSB);
    directed("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 3'b001, LAT_MSB);
    directed("lt_1000_2000", 16'h1000, 16'h2000, 1'b0, 3'b001, LAT_MSB);
    directed("s_neg_eq", 16'hFFFE, 16'hFFFE, 1'b1, 3'b010, LAT_FULL);
    directed("s_m1_vs_1", 16'hFFFF, 16'h0001, 1'b1, 3'b001, LAT_MSB);

    // Starts during RUN/DONE are ignored; the held start lands in the IDLE cycle after DONE
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1000; b = 16'h2000; sgn = 1'b0;
    @(posedge clk); #1;
    begin
      int lat;
      lat = 1;
      while (!done_op && lat < 40) begin
        a = W'($urandom); b = W'($urandom); sgn = 1'($urandom);
        @(posedge clk); #1;
        lat++;
      end
      check("ignore_latency", lat, LAT_MSB);
    end
    check("ignore_flags", {a_op_G, a_op_E_b, b_op_G}, 3'b001);
    a = 16'h00F1; b = 16'h00F0; sgn = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle_ready", ready_op, 1'b1);
    @(posedge clk); #1;
    check("b2b_accepted", busy_op, 1'b1);
    start = 1'b0;
    wait_done("b2b", LAT_FULL);
    check("b2b_flags", {a_op_G, a_op_E_b, b_op_G}, 3'b100);

    // Reset in RUN cycle 2 abandons the compare
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1234; b = 16'h1235; sgn = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_ready", ready_op, 1'b1);
    check("rst_mid_busy", busy_op, 1'b0);
    check("rst_mid_flags", {a_op_G, a_op_E_b, b_op_G}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("rst_no_done", done_op, 1'b0);
      @(posedge clk); #1;
    end
    directed("after_rst_00f1", 16'h00F1, 16'h00F0, 1'b0, 3'b100, LAT_FULL);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) != 0);
      sgn   = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin a = W'($urandom); b = a; end
        1: begin a = W'($urandom); b = a ^ (W'(1) << $urandom_range(0, W - 1)); end
        2: begin a = W'($urandom); b = a ^ W'($urandom_range(1, 15)); end
        default: begin a = W'($urandom); b = W'($urandom); end
      endcase
    end
    rst = 1'b0;
    start = 1'b0;
    wait_ready();
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
